// File: rtl/ext_periph_regbank_if.sv
// ext_periph_regbank_if: RVCORE_TOP external bus (strobe, byte enables, word address, write/read data)
interface ext_periph_regbank_if #(parameter int AWIDTH = 16);
    logic              EXT_EN;
    logic [3:0]        EXT_WEA;
    logic [AWIDTH-1:0] EXT_ADDR;
    logic [31:0]       EXT_DIN;
    logic [31:0]       EXT_DOUT;
    modport master (output EXT_EN, EXT_WEA, EXT_ADDR, EXT_DIN, input EXT_DOUT);
    modport slave (input EXT_EN, EXT_WEA, EXT_ADDR, EXT_DIN, output EXT_DOUT);
endinterface

// File: rtl/ext_periph_regbank.sv
// ext_periph_regbank: ID/CFG, coherent 64-bit cycle counter, mailbox FIFO, scratch regs; irq port under EXT_PERIPH_IRQ_EN
module ext_periph_regbank #(
    parameter int          AWIDTH      = 16,
    parameter int          NUM_SCRATCH = 4,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [31:0] ID_VALUE    = 32'h5253_0002
) (
    input logic clk,
    input logic rst,
    ext_periph_regbank_if.slave bus
`ifdef EXT_PERIPH_IRQ_EN
    ,
    output logic irq
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int FW = PW + 1;
    logic [31:0] dout_q, dout_d, ctrl_q, ctrl_d, hi_q, hi_d, rdata, scr_rd, stat;
    logic [63:0] cnt_q, cnt_d;
    logic [31:0] scr_q [NUM_SCRATCH];
    logic [31:0] scr_d [NUM_SCRATCH];
    logic [31:0] mem_q [FIFO_DEPTH];
    logic [31:0] mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic ovf_q, ovf_d, udf_q, udf_d;
    logic rd_en, wr_en, empty, full;
    assign rd_en = bus.EXT_EN && bus.EXT_WEA == 4'h0;
    assign wr_en = bus.EXT_EN && bus.EXT_WEA != 4'h0;
    assign empty = fcnt_q == '0;
    assign full = fcnt_q == FW'(FIFO_DEPTH);
    assign stat = {16'h0, 8'(fcnt_q), 4'h0, ovf_q, udf_q, full, empty};
    assign bus.EXT_DOUT = dout_q;
    always_comb begin
        scr_rd = '0;
        for (int i = 0; i < NUM_SCRATCH; i++)
            if (bus.EXT_ADDR == AWIDTH'(16 + i)) scr_rd = scr_q[i];
        rdata = bus.EXT_ADDR == AWIDTH'(0) ? ID_VALUE :
                bus.EXT_ADDR == AWIDTH'(1) ? {8'(NUM_SCRATCH), 8'(FIFO_DEPTH), 16'h0001} :
                bus.EXT_ADDR == AWIDTH'(2) ? cnt_q[31:0] :
                bus.EXT_ADDR == AWIDTH'(3) ? hi_q :
                bus.EXT_ADDR == AWIDTH'(4) ? (empty ? 32'h0 : mem_q[rd_q]) :
                bus.EXT_ADDR == AWIDTH'(5) ? stat :
                bus.EXT_ADDR == AWIDTH'(6) ? ctrl_q : scr_rd;
    end
    always_comb begin
        dout_d = dout_q;
        ctrl_d = ctrl_q;
        cnt_d = ctrl_q[0] ? cnt_q + 64'd1 : cnt_q;
        hi_d = hi_q;
        scr_d = scr_q;
        mem_d = mem_q;
        wr_d = wr_q;
        rd_d = rd_q;
        fcnt_d = fcnt_q;
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (rd_en) begin
            dout_d = rdata;
            if (bus.EXT_ADDR == AWIDTH'(2)) hi_d = cnt_q[63:32];
            if (bus.EXT_ADDR == AWIDTH'(4)) begin
                udf_d = udf_q | empty;
                rd_d = empty ? rd_q : rd_q + 1'b1;
                fcnt_d = empty ? fcnt_q : fcnt_q - 1'b1;
            end
        end
        if (wr_en) begin
            if (bus.EXT_ADDR == AWIDTH'(4)) begin
                ovf_d = ovf_q | full;
                if (!full) mem_d[wr_q] = bus.EXT_DIN;
                wr_d = full ? wr_q : wr_q + 1'b1;
                fcnt_d = full ? fcnt_q : fcnt_q + 1'b1;
            end
            if (bus.EXT_ADDR == AWIDTH'(5)) begin
                ovf_d = ovf_q & ~bus.EXT_DIN[3];
                udf_d = udf_q & ~bus.EXT_DIN[2];
            end
            if (bus.EXT_ADDR == AWIDTH'(6) && bus.EXT_WEA[0]) begin
                ctrl_d = {29'h0, bus.EXT_DIN[2], 1'b0, bus.EXT_DIN[0]};
                if (bus.EXT_DIN[1]) begin
                    wr_d = '0;
                    rd_d = '0;
                    fcnt_d = '0;
                end
            end
            for (int i = 0; i < NUM_SCRATCH; i++)
                for (int b = 0; b < 4; b++)
                    if (bus.EXT_ADDR == AWIDTH'(16 + i) && bus.EXT_WEA[b])
                        scr_d[i][8*b +: 8] = bus.EXT_DIN[8*b +: 8];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
            ctrl_q <= 32'h1;
            cnt_q <= '0;
            hi_q <= '0;
            for (int i = 0; i < NUM_SCRATCH; i++) scr_q[i] <= '0;
            wr_q <= '0;
            rd_q <= '0;
            fcnt_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            dout_q <= dout_d;
            ctrl_q <= ctrl_d;
            cnt_q <= cnt_d;
            hi_q <= hi_d;
            scr_q <= scr_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            fcnt_q <= fcnt_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
        mem_q <= mem_d;
    end
`ifdef EXT_PERIPH_IRQ_EN
    logic irq_q, irq_d;
    assign irq_d = ctrl_q[2] & (~empty | ovf_q);
    always_ff @(posedge clk) irq_q <= rst ? 1'b0 : irq_d;
    assign irq = irq_q;
`endif
endmodule
